// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter:
// FSM encoding, port owner and the word/mask widths.
package mem_port_arbiter_pkg;

    localparam int WORD_W = 32;
    localparam int MASK_W = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [MASK_W-1:0] mask_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// arb_starve_cnt: saturating count of fetch arbitration losses.
// Only instantiated when MEM_PORT_ARB_STARVE_GUARD_EN is defined.
module arb_starve_cnt #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic lose,
    input  logic clr,
    output logic starved
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (lose && (cnt_q < 4'(LIMIT))) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved = (cnt_q >= 4'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data stages, one
// transaction outstanding. MEM_PORT_ARB_STARVE_GUARD_EN adds fetch promotion.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_wmask,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;
    logic       drop_q, drop_d;
    logic       we_q, we_d;
    mask_t      wmask_q, wmask_d;
    word_t      addr_q, addr_d;
    word_t      wdata_q, wdata_d;
    logic       done;
    logic       starved;

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    arb_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .lose   (dm_gnt && if_req),
        .clr    (if_gnt),
        .starved(starved)
    );
`else
    // Limit has no effect here; the expression folds to 0.
    assign starved = (STARVE_LIMIT < 0);
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        drop_d  = drop_q;
        we_d    = we_q;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if_gnt  = 1'b0;
        dm_gnt  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (if_req && (!dm_req || starved)) begin
                    if_gnt  = 1'b1;
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    wmask_d = '0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    drop_d  = flush;
                    state_d = REQ;
                end else if (dm_req) begin
                    dm_gnt  = 1'b1;
                    owner_d = OWN_DM;
                    we_d    = dm_we;
                    wmask_d = dm_wmask;
                    addr_d  = dm_addr;
                    wdata_d = dm_wdata;
                    drop_d  = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    done    = mem_rvalid;
                    state_d = mem_rvalid ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && (owner_q == OWN_IF) && flush) begin
            drop_d = 1'b1;
        end
        if (done) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            drop_q  <= 1'b0;
            we_q    <= 1'b0;
            wmask_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            we_q    <= we_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_wmask = wmask_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // A flush landing on the completion cycle also suppresses the fetch data.
    assign if_rvalid = done && (owner_q == OWN_IF) && !(drop_q || flush);
    assign dm_rvalid = done && (owner_q == OWN_DM);
    assign if_rdata  = (state_q != IDLE) ? mem_rdata : '0;
    assign dm_rdata  = (state_q != IDLE) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction model predicts
// grants, accepted commands and responses, a monitor pops and compares.
module tb_mem_port_arbiter;

    localparam int LIM = 2;
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [3:0]  dm_wmask;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        flush;
    logic        mem_req, mem_we, mem_ack, mem_rvalid;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_wmask(dm_wmask),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wmask(mem_wmask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          who;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    ev_t  gnt_q[$];
    ev_t  rsp_q[$];
    cmd_t cmd_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // model: who = 0 fetch, 1 data
    bit   m_busy, m_acked, m_own, m_drop;
    int   m_starve;
    cmd_t m_cmd;

    logic [31:0] d_ia, d_da, d_wd, d_rd;
    logic [3:0]  d_mk;
    logic        d_we;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_acked = 0; m_own = 0; m_drop = 0; m_starve = 0;
    endtask

    task automatic step(input bit ifr, input bit dmr, input bit ack,
                        input bit rv, input bit fl);
        bit fw;
        bit done;
        @(posedge clk);
        #1;
        cyc++;
        if_req = ifr; if_addr = d_ia;
        dm_req = dmr; dm_we = d_we; dm_wmask = d_mk;
        dm_addr = d_da; dm_wdata = d_wd;
        flush = fl; mem_ack = ack; mem_rvalid = rv; mem_rdata = d_rd;
        done = 0;
        if (!m_busy) begin
            if (ifr || dmr) begin
                fw = ifr && (!dmr || (GUARD && m_starve >= LIM));
                gnt_q.push_back('{cyc: cyc, who: !fw, data: 32'd0});
                if (fw) begin
                    m_cmd = '{cyc: 0, we: 1'b0, mask: 4'd0, addr: d_ia, wdata: 32'd0};
                    m_starve = 0;
                    m_drop = fl;
                end else begin
                    m_cmd = '{cyc: 0, we: d_we, mask: d_mk, addr: d_da, wdata: d_wd};
                    if (ifr && m_starve < LIM) m_starve++;
                    m_drop = 0;
                end
                m_own = !fw;
                m_busy = 1;
                m_acked = 0;
            end
        end else begin
            if (!m_own && fl) m_drop = 1;
            if (!m_acked) begin
                if (ack) begin
                    m_cmd.cyc = cyc;
                    cmd_q.push_back(m_cmd);
                    if (rv) done = 1;
                    else m_acked = 1;
                end
            end else if (rv) begin
                done = 1;
            end
            if (done) begin
                if (m_own || !m_drop)
                    rsp_q.push_back('{cyc: cyc, who: m_own, data: d_rd});
                m_busy = 0;
                m_drop = 0;
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {58'd0, mem_req, mem_we, if_gnt, dm_gnt,
              if_rvalid, dm_rvalid}, 64'd0);
        check({tag, "_addr"}, {32'd0, mem_addr}, 64'd0);
        check({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
        check({tag, "_wmask"}, {60'd0, mem_wmask}, 64'd0);
        check({tag, "_if_rdata"}, {32'd0, if_rdata}, 64'd0);
        check({tag, "_dm_rdata"}, {32'd0, dm_rdata}, 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1; if_req = 0; dm_req = 0; flush = 0; mem_ack = 0;
        mem_rvalid = 1; mem_rdata = $urandom | 32'h1;
        #1;
        check_quiet(tag);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        d_rd = 32'hA5A5_0001;
        step(0, 0, 0, 1, 0);
        #1;
        check_quiet({tag, "_post"});
    endtask

    // monitor
    initial begin
        ev_t  e;
        cmd_t c;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (if_gnt || dm_gnt) begin
                if (gnt_q.size() == 0) begin
                    check("gnt_unexpected", {62'd0, if_gnt, dm_gnt}, 64'd0);
                end else begin
                    e = gnt_q.pop_front();
                    check("gnt_cyc", 64'(cyc), 64'(e.cyc));
                    check("gnt_who", {62'd0, if_gnt, dm_gnt},
                          e.who ? 64'd1 : 64'd2);
                end
            end
            if (mem_req && mem_ack) begin
                if (cmd_q.size() == 0) begin
                    check("cmd_unexpected", {63'd0, mem_req}, 64'd0);
                end else begin
                    c = cmd_q.pop_front();
                    check("cmd_cyc", 64'(cyc), 64'(c.cyc));
                    check("cmd_addr_we", {27'd0, mem_we, mem_wmask, mem_addr},
                          {27'd0, c.we, c.mask, c.addr});
                    check("cmd_wdata", {32'd0, mem_wdata}, {32'd0, c.wdata});
                end
            end
            if (if_rvalid || dm_rvalid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", {62'd0, if_rvalid, dm_rvalid}, 64'd0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_cyc", 64'(cyc), 64'(e.cyc));
                    check("rsp_who", {62'd0, if_rvalid, dm_rvalid},
                          e.who ? 64'd1 : 64'd2);
                    check("rsp_data", {32'd0, if_rvalid ? if_rdata : dm_rdata},
                          {32'd0, e.data});
                end
            end
        end
    end

    initial begin
        bit a, r;
        rst = 1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_wmask = 0; dm_addr = 0; dm_wdata = 0; flush = 0;
        mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
        d_ia = 0; d_da = 0; d_wd = 0; d_rd = 0; d_mk = 0; d_we = 0;
        model_reset();
        do_reset("rst0");

        // fetch only, ack next cycle, data two cycles later
        d_ia = 32'h100; d_rd = 32'hDEAD_BEEF;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);

        // simultaneous store and fetch: store first
        d_we = 1; d_da = 32'h200; d_wd = 32'h55; d_mk = 4'hF; d_rd = 32'h1234_5678;
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        d_rd = 32'hCAFE_F00D;
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        // back-to-back grant, then flush while waiting
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);

        // both requesters held high with a fast memory
        for (int i = 0; i < 24; i++) begin
            d_ia = $urandom; d_da = $urandom; d_rd = $urandom;
            a = m_busy && !m_acked;
            step(1, 1, a, a, 0);
        end
        while (m_busy) begin
            a = !m_acked;
            step(0, 0, a, 1, 0);
        end

        // reset while waiting on a fetch
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        do_reset("rst_wait");

        for (int i = 0; i < 3000; i++) begin
            d_ia = $urandom; d_da = $urandom; d_wd = $urandom; d_rd = $urandom;
            d_mk = 4'($urandom); d_we = 1'($urandom);
            if (!m_busy) begin
                a = 0; r = ($urandom_range(0, 4) == 0);
            end else if (!m_acked) begin
                a = 1'($urandom); r = a && ($urandom_range(0, 3) == 0);
            end else begin
                a = 0; r = ($urandom_range(0, 2) == 0);
            end
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
                 a, r, $urandom_range(0, 9) == 0);
            if (i == 1500) do_reset("rst_rand");
        end

        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("gnt_left", 64'(gnt_q.size()), 64'd0);
        check("cmd_left", 64'(cmd_q.size()), 64'd0);
        check("rsp_left", 64'(rsp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
